// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and fetch constants.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  localparam logic [15:0] NOP_INST = 16'h4300;
  localparam int          PC_STEP  = 2;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: walks a halfword PC over a req/ack memory port and
// delivers each instruction to the IR with a one-cycle ir_wen strobe.
//
// state  | meaning
// S_IDLE | one cycle after reset, memory ack ignored
// S_REQ  | request outstanding at fetch_pc (or squashed wrong-path request)
// S_HOLD | one fetched instruction buffered while decode stalls
module inst_fetch #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]     NOP_INST = ifu_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       inst_out,
  output logic              ir_wen,
  output logic [ADDR_W-1:0] pc_out
);

  import ifu_pkg::*;

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [15:0]       hold_buf_q, hold_buf_d;
  logic [15:0]       inst_q, inst_d;
  logic              squash_q, squash_d;
  logic              ir_wen_q, ir_wen_d;

  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next;

  assign target  = branch_target & ~ADDR_W'(1);
  assign pc_next = fetch_pc_q + ADDR_W'(PC_STEP);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    hold_pc_d  = hold_pc_q;
    hold_buf_d = hold_buf_q;
    pc_out_d   = pc_out_q;
    inst_d     = inst_q;
    squash_d   = squash_q;
    ir_wen_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (branch_valid) fetch_pc_d = target;
      end

      S_REQ: begin
        if (squash_q) begin
          // Wrong-path request still in flight: drop its data, then go to the target.
          if (imem_ack) begin
            squash_d   = 1'b0;
            fetch_pc_d = branch_valid ? target : pend_pc_q;
          end else if (branch_valid) begin
            pend_pc_d = target;
          end
        end else if (branch_valid) begin
          if (imem_ack) begin
            fetch_pc_d = target;
          end else begin
            squash_d  = 1'b1;
            pend_pc_d = target;
          end
        end else if (imem_ack) begin
          fetch_pc_d = pc_next;
          if (stall) begin
            hold_buf_d = imem_rdata;
            hold_pc_d  = fetch_pc_q;
            state_d    = S_HOLD;
          end else begin
            inst_d   = imem_rdata;
            pc_out_d = fetch_pc_q;
            ir_wen_d = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (branch_valid) begin
          fetch_pc_d = target;
          state_d    = S_REQ;
        end else if (!stall) begin
          inst_d   = hold_buf_q;
          pc_out_d = hold_pc_q;
          ir_wen_d = 1'b1;
          state_d  = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      hold_pc_q  <= RESET_PC;
      hold_buf_q <= NOP_INST;
      pc_out_q   <= RESET_PC;
      inst_q     <= NOP_INST;
      squash_q   <= 1'b0;
      ir_wen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      hold_pc_q  <= hold_pc_d;
      hold_buf_q <= hold_buf_d;
      pc_out_q   <= pc_out_d;
      inst_q     <= inst_d;
      squash_q   <= squash_d;
      ir_wen_q   <= ir_wen_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = fetch_pc_q;
  assign inst_out  = inst_q;
  assign ir_wen    = ir_wen_q;
  assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, stall hold, redirects, wrap and reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] inst_out;
  logic        ir_wen;
  logic [15:0] pc_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_out     (inst_out),
    .ir_wen       (ir_wen),
    .pc_out       (pc_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deliv(input string tag, input logic [15:0] inst, input logic [15:0] pc);
    check({tag, "_wen"}, 32'(ir_wen), 32'd1);
    check({tag, "_inst"}, 32'(inst_out), 32'(inst));
    check({tag, "_pc"}, 32'(pc_out), 32'(pc));
  endtask

  initial begin
    resetn = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    tick(); tick();
    check("rst_inst", 32'(inst_out), 32'h4300);
    check("rst_wen", 32'(ir_wen), 32'd0);
    check("rst_pc", 32'(pc_out), 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);

    // Sequential fetch, ack every cycle
    resetn = 1'b1;
    tick();
    check("seq_req", 32'(imem_req), 32'd1);
    check("seq_addr0", 32'(imem_addr), 32'h0);
    imem_ack = 1'b1; imem_rdata = 16'h1111;
    tick();
    deliv("seq1", 16'h1111, 16'h0000);
    check("seq_addr1", 32'(imem_addr), 32'h2);
    imem_rdata = 16'h2222;
    tick();
    deliv("seq2", 16'h2222, 16'h0002);
    check("seq_addr2", 32'(imem_addr), 32'h4);
    imem_rdata = 16'h3333;
    tick();
    deliv("seq3", 16'h3333, 16'h0004);
    imem_ack = 1'b0;
    tick();
    check("seq_idle_wen", 32'(ir_wen), 32'd0);
    check("seq_addr3", 32'(imem_addr), 32'h6);

    // Stall with ack: instruction is held, then delivered once
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hABCD;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stl_wen", 32'(ir_wen), 32'd0);
      check("stl_req", 32'(imem_req), 32'd0);
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    deliv("stl_rel", 16'hABCD, 16'h0006);
    check("stl_req_back", 32'(imem_req), 32'd1);
    check("stl_addr", 32'(imem_addr), 32'h8);
    tick();
    check("stl_nodup", 32'(ir_wen), 32'd0);

    // Redirect while a request is pending without ack
    branch_valid = 1'b1; branch_target = 16'h0101;
    tick();
    branch_valid = 1'b0;
    check("sq_addr_hold", 32'(imem_addr), 32'h8);
    check("sq_wen", 32'(ir_wen), 32'd0);
    tick();
    check("sq_addr_hold2", 32'(imem_addr), 32'h8);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    check("sq_drop_wen", 32'(ir_wen), 32'd0);
    check("sq_drop_inst", 32'(inst_out), 32'hABCD);
    check("sq_tgt_addr", 32'(imem_addr), 32'h0100);
    check("sq_tgt_req", 32'(imem_req), 32'd1);

    // Redirect + stall + ack in the same cycle
    branch_valid = 1'b1; branch_target = 16'h0200; stall = 1'b1;
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    branch_valid = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    check("bs_wen", 32'(ir_wen), 32'd0);
    check("bs_inst", 32'(inst_out), 32'hABCD);
    check("bs_addr", 32'(imem_addr), 32'h0200);
    check("bs_req", 32'(imem_req), 32'd1);

    // Wrap: redirect to odd FFFF (bit 0 cleared), then fetch twice
    branch_valid = 1'b1; branch_target = 16'hFFFF; imem_ack = 1'b1; imem_rdata = 16'h0000;
    tick();
    branch_valid = 1'b0;
    check("wr_addr", 32'(imem_addr), 32'hFFFE);
    check("wr_drop", 32'(ir_wen), 32'd0);
    imem_rdata = 16'h7777;
    tick();
    deliv("wr1", 16'h7777, 16'hFFFE);
    check("wr_addr_wrap", 32'(imem_addr), 32'h0000);
    imem_rdata = 16'h8888;
    tick();
    deliv("wr2", 16'h8888, 16'h0000);
    imem_ack = 1'b0;
    tick();
    check("wr_pend", 32'(imem_req), 32'd1);

    // Reset mid-request, ack during S_IDLE ignored
    resetn = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h9999;
    tick();
    resetn = 1'b1;
    check("mr_inst", 32'(inst_out), 32'h4300);
    check("mr_wen", 32'(ir_wen), 32'd0);
    check("mr_req", 32'(imem_req), 32'd0);
    check("mr_pc", 32'(pc_out), 32'h0);
    tick();
    check("mr_idle_ign_wen", 32'(ir_wen), 32'd0);
    check("mr_idle_ign_inst", 32'(inst_out), 32'h4300);
    check("mr_restart_req", 32'(imem_req), 32'd1);
    check("mr_restart_addr", 32'(imem_addr), 32'h0);
    imem_rdata = 16'hAAAA;
    tick();
    deliv("mr_first", 16'hAAAA, 16'h0000);
    imem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
